// File: rtl/alu_issue_ctrl.sv
// Issue/writeback sequencer for a combinational 4-bit ALU.
// Holds a 4 x 4-bit register file and the C/V flags. It registers the ALU
// operand/opcode inputs for one execute cycle, then captures the ALU result.
module alu_issue_ctrl #(
    parameter int          NREG   = 4,
    parameter logic [3:0]  NOP_OP = 4'b0011
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_ld,
    input  logic [3:0]  in_op,
    input  logic [1:0]  in_rd,
    input  logic [1:0]  in_ra,
    input  logic [1:0]  in_rb,
    input  logic [3:0]  in_imm,
    output logic [3:0]  alu_a,
    output logic [3:0]  alu_b,
    output logic [3:0]  alu_opcode,
    output logic        alu_cin,
    input  logic [3:0]  alu_sum,
    input  logic        alu_cout,
    input  logic        alu_of,
    output logic        out_valid,
    output logic [1:0]  out_rd,
    output logic [3:0]  out_data,
    output logic        c_flag,
    output logic        v_flag
);

    typedef enum logic {IDLE = 1'b0, EXEC = 1'b1} state_t;

    // Opcodes the ALU actually implements; anything else is treated as a NOP.
    function automatic logic op_is_valid(input logic [3:0] op);
        case (op)
            4'b1000, 4'b1010, 4'b1001, 4'b0000, 4'b0001,
            4'b0010, 4'b0100, 4'b0101, 4'b1111: op_is_valid = 1'b1;
            default:                            op_is_valid = 1'b0;
        endcase
    endfunction

    // Only the arithmetic opcodes (add, sub, add-with-carry) touch the flags.
    function automatic logic op_sets_flags(input logic [3:0] op);
        case (op)
            4'b1000, 4'b1010, 4'b1001: op_sets_flags = 1'b1;
            default:                   op_sets_flags = 1'b0;
        endcase
    endfunction

    state_t      state_q, state_d;
    logic [3:0]  regs_q [NREG];
    logic [3:0]  regs_d [NREG];
    logic        c_q, c_d, v_q, v_d;
    logic [1:0]  rd_q, rd_d;
    logic [3:0]  alu_a_q, alu_a_d, alu_b_q, alu_b_d, alu_op_q, alu_op_d;
    logic        alu_cin_q, alu_cin_d;
    logic        out_valid_q, out_valid_d;
    logic [1:0]  out_rd_q, out_rd_d;
    logic [3:0]  out_data_q, out_data_d;
    logic        accept_s;

    assign in_ready   = (state_q == IDLE) && !rst;
    assign accept_s   = in_valid && in_ready;

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_opcode = alu_op_q;
    assign alu_cin    = alu_cin_q;
    assign out_valid  = out_valid_q;
    assign out_rd     = out_rd_q;
    assign out_data   = out_data_q;
    assign c_flag     = c_q;
    assign v_flag     = v_q;

    // Next-state: accept/issue in IDLE, ALU writeback and port release in EXEC.
    always_comb begin
        state_d     = state_q;
        regs_d      = regs_q;
        c_d         = c_q;
        v_d         = v_q;
        rd_d        = rd_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_op_d    = alu_op_q;
        alu_cin_d   = alu_cin_q;
        out_valid_d = 1'b0;
        out_rd_d    = out_rd_q;
        out_data_d  = out_data_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    if (in_ld) begin
                        regs_d[in_rd] = in_imm;
                        out_valid_d   = 1'b1;
                        out_rd_d      = in_rd;
                        out_data_d    = in_imm;
                    end else begin
                        alu_a_d   = regs_q[in_ra];
                        alu_b_d   = regs_q[in_rb];
                        alu_op_d  = in_op;
                        alu_cin_d = c_q;
                        rd_d      = in_rd;
                        state_d   = EXEC;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            EXEC: begin
                if (op_is_valid(alu_op_q)) begin
                    regs_d[rd_q] = alu_sum;
                    out_valid_d  = 1'b1;
                    out_rd_d     = rd_q;
                    out_data_d   = alu_sum;
                    if (op_sets_flags(alu_op_q)) begin
                        c_d = alu_cout;
                        v_d = alu_of;
                    end else begin
                        c_d = c_q;
                        v_d = v_q;
                    end
                end else begin
                    out_valid_d = 1'b0;
                end
                alu_a_d   = 4'd0;
                alu_b_d   = 4'd0;
                alu_op_d  = NOP_OP;
                alu_cin_d = 1'b0;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register with synchronous reset; reset discards any op in EXEC.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= 4'd0;
            end
            c_q         <= 1'b0;
            v_q         <= 1'b0;
            rd_q        <= 2'd0;
            alu_a_q     <= 4'd0;
            alu_b_q     <= 4'd0;
            alu_op_q    <= NOP_OP;
            alu_cin_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_rd_q    <= 2'd0;
            out_data_q  <= 4'd0;
        end else begin
            state_q     <= state_d;
            regs_q      <= regs_d;
            c_q         <= c_d;
            v_q         <= v_d;
            rd_q        <= rd_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            alu_cin_q   <= alu_cin_d;
            out_valid_q <= out_valid_d;
            out_rd_q    <= out_rd_d;
            out_data_q  <= out_data_d;
        end
    end

endmodule
